serial_adder_ctrl: RTL and testbench

Bit-serial multi-bit adder controller built around a single instance of the team's one-bit full_adder cell (ports a, b, cin, s, cout).
- Latches two WIDTH-bit operands and a carry-in on a start request.
- Feeds one bit pair per clock, LSB first, through the full_adder and keeps the ripple carry in a flip-flop.
- Presents the registered sum, carry-out and a one-cycle done pulse.
- Serves as the lab's sequential wrapper for area-minimal addition.

---
 rtl/serial_adder_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell, one bit pair per clock,
// LSB first, with the ripple carry held in a flip-flop between cycles.
// The result and carry-out are registered and only update on the edge that
// raises the one-cycle done pulse.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Bit counter needs to reach WIDTH-1; a 1-bit counter still exists for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_rSh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_rNext;

  // The single adder cell; the carry chain is built over time through r_carry.
  full_adder u_fa (
    .a    (r_aSh[0]),
    .b    (r_bSh[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // Next result shift value: new sum bit enters at the MSB, older bits move down.
  always_comb begin
    w_rNext            = r_rSh >> 1;
    w_rNext[WIDTH-1]   = w_s;
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control; start is only honoured in IDLE or DONE.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand/result shifting, carry flop and bit counter; sum/cout latch on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSh   <= '0;
      r_bSh   <= '0;
      r_rSh   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_aSh   <= a;
      r_bSh   <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_aSh   <= r_aSh >> 1;
      r_bSh   <= r_bSh >> 1;
      r_rSh   <= w_rNext;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_rNext;
        r_cout <= w_cout;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the main
// scenarios plus 2-bit and 1-bit instances checked exhaustively.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge on the 8-bit instance; returns #1 after the accepting edge.
  task automatic applyStimulus8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Wait for done on the 8-bit instance, counting cycles since accept and busy cycles.
  task automatic waitDone8(input int limit, output int cycles, output int busyCycles,
                           output bit timedOut);
    cycles = 0; busyCycles = 0; timedOut = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      if (busy8) busyCycles++;
      tick();
      cycles = i;
      if (done8) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    tick(); tick();
    compared++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_w8: got busy=%0b done=%0b cout=%0b sum=%h expected all zero",
               busy8, done8, cout8, sum8);
    end
    compared++;
    if ({busy2, done2, cout2, sum2, busy1, done1, cout1, sum1} !== 9'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_w2w1: got %b/%b/%b/%b %b/%b/%b/%b expected all zero",
               busy2, done2, cout2, sum2, busy1, done1, cout1, sum1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    bit to;
    applyStimulus8(8'h5A, 8'h3C, 1'b0);
    compared++;
    if (busy8 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic_busy_after_accept: got %0b expected 1", busy8);
    end
    waitDone8(20, cyc, bcyc, to);
    compared++;
    if (to || cyc != 8) begin
      mismatched++;
      $display("[TB] FAIL basic_latency: got %0d cycles (timeout=%0b) expected 8", cyc, to);
    end
    compared++;
    if (bcyc != 8 || busy8 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_busy_len: got %0d busy cycles, busy at done=%0b expected 8/0",
               bcyc, busy8);
    end
    compared++;
    if (sum8 !== 8'h96 || cout8 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_result: got sum=%h cout=%0b expected 96/0", sum8, cout8);
    end
    tick();
    compared++;
    if (done8 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_done_pulse: got done=%0b expected 0", done8);
    end
  endtask

  task automatic test_carry();
    logic [7:0] ta[3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] tb[3] = '{8'h01, 8'hFF, 8'h00};
    logic       tc[3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] es[3] = '{8'h00, 8'hFF, 8'h01};
    logic       ec[3] = '{1'b1, 1'b1, 1'b0};
    int cyc, bcyc;
    bit to;
    for (int k = 0; k < 3; k++) begin
      applyStimulus8(ta[k], tb[k], tc[k]);
      waitDone8(20, cyc, bcyc, to);
      compared++;
      if (to || sum8 !== es[k] || cout8 !== ec[k]) begin
        mismatched++;
        $display("[TB] FAIL carry_vec%0d: got sum=%h cout=%0b timeout=%0b expected %h/%0b",
                 k, sum8, cout8, to, es[k], ec[k]);
      end
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int firstDone = 0;
    int doneCount = 0;
    applyStimulus8(8'h12, 8'h34, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else if (i == 3) begin
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
      end
      tick();
      if (done8) begin
        doneCount++;
        if (firstDone == 0) firstDone = i;
      end
    end
    compared++;
    if (firstDone != 8 || doneCount != 1) begin
      mismatched++;
      $display("[TB] FAIL ignore_start_done: got first=%0d count=%0d expected 8/1",
               firstDone, doneCount);
    end
    compared++;
    if (sum8 !== 8'h46 || cout8 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ignore_start_result: got sum=%h cout=%0b expected 46/0", sum8, cout8);
    end
  endtask

  task automatic test_reset_mid_run();
    int doneCount = 0;
    int cyc, bcyc;
    bit to;
    applyStimulus8(8'h80, 8'h80, 1'b0);
    tick(); tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    compared++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset: got busy=%0b done=%0b cout=%0b sum=%h expected all zero",
               busy8, done8, cout8, sum8);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) doneCount++;
    end
    compared++;
    if (doneCount != 0) begin
      mismatched++;
      $display("[TB] FAIL midrun_no_done: got %0d active cycles expected 0", doneCount);
    end
    applyStimulus8(8'h01, 8'h02, 1'b0);
    waitDone8(20, cyc, bcyc, to);
    compared++;
    if (to || sum8 !== 8'h03 || cout8 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midrun_recover: got sum=%h cout=%0b timeout=%0b expected 03/0",
               sum8, cout8, to);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int c1, c2, bcyc;
    bit to1, to2;
    a8 = 8'h21; b8 = 8'h43; cin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h10; b8 = 8'h0F;
    waitDone8(20, c1, bcyc, to1);
    compared++;
    if (to1 || c1 != 8 || sum8 !== 8'h64 || cout8 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got cycles=%0d sum=%h cout=%0b expected 8/64/0",
               c1, sum8, cout8);
    end
    tick();
    compared++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_rebusy: got busy=%0b done=%0b expected 1/0", busy8, done8);
    end
    start8 = 1'b0;
    waitDone8(20, c2, bcyc, to2);
    compared++;
    if (to2 || (c2 + 1) != 9 || sum8 !== 8'h1F || cout8 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got gap=%0d sum=%h cout=%0b expected 9/1f/0",
               c2 + 1, sum8, cout8);
    end
    tick();
  endtask

  task automatic test_width2();
    int cyc;
    bit to;
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a2 = 2'(ai); b2 = 2'(bi); cin2 = 1'(ci); start2 = 1'b1;
          tick();
          start2 = 1'b0;
          to = 1'b1; cyc = 0;
          for (int i = 1; i <= 10; i++) begin
            tick();
            cyc = i;
            if (done2) begin to = 1'b0; break; end
          end
          compared++;
          if (to || cyc != 2 || {cout2, sum2} !== 3'(ai + bi + ci)) begin
            mismatched++;
            $display("[TB] FAIL w2_%0d_%0d_%0d: got cycles=%0d {cout,sum}=%b expected 2/%b",
                     ai, bi, ci, cyc, {cout2, sum2}, 3'(ai + bi + ci));
          end
        end
      end
    end
    tick();
  endtask

  task automatic test_width1();
    int cyc;
    bit to;
    for (int ai = 0; ai < 2; ai++) begin
      for (int bi = 0; bi < 2; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a1 = 1'(ai); b1 = 1'(bi); cin1 = 1'(ci); start1 = 1'b1;
          tick();
          start1 = 1'b0;
          to = 1'b1; cyc = 0;
          for (int i = 1; i <= 10; i++) begin
            tick();
            cyc = i;
            if (done1) begin to = 1'b0; break; end
          end
          compared++;
          if (to || cyc != 1 || {cout1, sum1} !== 2'(ai + bi + ci)) begin
            mismatched++;
            $display("[TB] FAIL w1_%0d_%0d_%0d: got cycles=%0d {cout,sum}=%b expected 1/%b",
                     ai, bi, ci, cyc, {cout1, sum1}, 2'(ai + bi + ci));
          end
        end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_width2();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
